mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the RAM word-address width.
REQ-002 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have, per requester k in {0,1}: mk_req in 1, mk_we in 1, mk_addr in 32 (byte address), mk_wdata in 32, mk_len in 2 (0=B, 1=H, 2=W), mk_sign in 1 (1=sign-extend loads).
REQ-005 SHALL have, per requester k: mk_gnt out 1 (accept pulse), mk_rvalid out 1 (read data valid), mk_rdata out 32, mk_err out 1 (misaligned or illegal-length pulse).
REQ-006 SHALL have RAM ports: ram_en out 1, ram_we out 4 (byte lanes), ram_addr out ADDR_W, ram_wdata out 32, and ram_rdata in 32 (registered RAM, 1-cycle read latency).
REQ-007 SHALL have busy out 1, high whenever the state is not IDLE.

Function
REQ-008 SHALL implement the states IDLE, ACCESS and RESP, registered.
REQ-009 In IDLE, SHALL sample the requests at the rising edge of cycle N and, if any is high, pick a winner, latch its we, addr, wdata, len and sign, and enter ACCESS at N+1.
REQ-010 In ACCESS, SHALL pulse gnt to the winner for 1 cycle, drive ram_en=1, and drive ram_addr=addr[ADDR_W+1:2].
REQ-011 A write SHALL drive ram_we during ACCESS and then return to IDLE, with no rvalid.
REQ-012 A read SHALL drive ram_we=0 in ACCESS, enter RESP, and in RESP pulse rvalid for 1 cycle with rdata extracted from ram_rdata; the read latency is req sampled at N to rvalid at N+2.
REQ-013 SHALL generate lanes as follows: B gives ram_we=1<<addr[1:0] with the byte replicated 4x on ram_wdata; H gives 0011 or 1100 per addr[1] with the half replicated 2x; W gives 1111.
REQ-014 Load extraction SHALL select the byte or half by addr[1:0] and then zero- or sign-extend it per sign; W SHALL pass through unchanged.
REQ-015 SHALL treat H with addr[0]=1, W with addr[1:0]!=0, and len=3 as errors: err pulses in the ACCESS cycle, ram_en=0, ram_we=0, no gnt, no rvalid, and the next state is IDLE.
REQ-016 A requester SHALL hold req and its attributes stable until it receives gnt or err; a req dropped before acceptance is ignored.
REQ-017 A request arriving while busy SHALL wait; it is evaluated only in IDLE.
REQ-018 mk_rdata SHALL be 0 whenever mk_rvalid=0; gnt, rvalid and err SHALL never be high for both ports in the same cycle.
REQ-019 All outputs except mk_rdata SHALL be registered or decoded from state plus latched attributes, never combinationally from mk_req.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, set all outputs to 0, and set the RR pointer to "m1 last".
REQ-021 A reset mid-transaction SHALL abort it: no gnt, rvalid or err is issued afterwards, and the requester must re-request.

Configuration
REQ-022 With MEM_ARB_RR_EN defined, SHALL use round-robin arbitration: on simultaneous requests the port not granted last wins, with the pointer updated on each gnt or err.
REQ-023 Without MEM_ARB_RR_EN, SHALL use fixed priority with m0 always winning; the pointer logic is absent.

Structure
REQ-024 Shared package cpu_mem_pkg SHALL hold the length codes LEN_B/LEN_H/LEN_W, the state encoding, and the lane-mask constants.
REQ-025 Lane generation and load extraction SHALL reside in one combinational sub-module, mem_lane_unit, which is instantiated once.

Verification
REQ-026 m0 W write 0xDEADBEEF to 0x10 -> ACCESS with ram_we=1111, ram_addr=4; a subsequent W read of 0x10 -> m0_rvalid 2 cycles after req with rdata 0xDEADBEEF.
REQ-027 Byte store 0xAB to 0x22 -> ram_we=0100, ram_wdata=0xABABABAB; a signed B read of 0x23 with word 0x80000000 -> 0xFFFFFF80, and unsigned -> 0x00000080.
REQ-028 m0 and m1 requesting together twice -> grant order m0, m1 with MEM_ARB_RR_EN, and m0, m0 without it.
REQ-029 m1 H read at 0x11 -> m1_err pulse at N+1, ram_en stays 0, no rvalid, busy low at N+2.
REQ-030 rst_n asserted during RESP -> all outputs 0 in the same cycle, no rvalid, and the next request is serviced normally.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory arbiter: access length codes, FSM state
// encoding and the byte-lane write masks.
package cpu_mem_pkg;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LANES_B    = 4'b0001;
    localparam logic [3:0] LANES_H_LO = 4'b0011;
    localparam logic [3:0] LANES_H_HI = 4'b1100;
    localparam logic [3:0] LANES_W    = 4'b1111;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane generation for stores, load extraction with zero/sign extension,
// and detection of misaligned or illegal-length accesses.
module mem_lane_unit
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  len,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  lanes,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        lanes     = '0;
        wdata_rep = wdata;
        rdata_ext = rdata;
        bad       = 1'b0;
        case (len)
            LEN_B: begin
                lanes     = LANES_B << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
            end
            LEN_H: begin
                lanes     = addr_lo[1] ? LANES_H_HI : LANES_H_LO;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
                bad       = addr_lo[0];
            end
            LEN_W: begin
                lanes = LANES_W;
                bad   = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-ported registered RAM with B/H/W accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [1:0]        m0_len,
    input  logic              m0_sign,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [1:0]        m1_len,
    input  logic              m1_sign,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    state_t            state;
    logic              win;
    logic              a_we;
    logic [ADDR_W+1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [1:0]        a_len;
    logic              a_sign;
    logic              pick;
    logic [3:0]        lanes;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              bad;
    logic              acc_ok;
    logic              acc_bad;
    logic              resp;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{m0_addr[31:ADDR_W+2], m1_addr[31:ADDR_W+2]};

`ifdef MEM_ARB_RR_EN
    logic last_m1;

    // pick = 1 selects m1; on a tie the port not served last wins
    always_comb pick = m1_req & (~m0_req | ~last_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_m1 <= 1'b1;
        else if (state == ST_ACCESS)
            last_m1 <= win;
    end
`else
    always_comb pick = ~m0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            win     <= 1'b0;
            a_we    <= 1'b0;
            a_addr  <= '0;
            a_wdata <= '0;
            a_len   <= '0;
            a_sign  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req | m1_req) begin
                        win     <= pick;
                        a_we    <= pick ? m1_we : m0_we;
                        a_addr  <= pick ? m1_addr[ADDR_W+1:0] : m0_addr[ADDR_W+1:0];
                        a_wdata <= pick ? m1_wdata : m0_wdata;
                        a_len   <= pick ? m1_len : m0_len;
                        a_sign  <= pick ? m1_sign : m0_sign;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= (!bad && !a_we) ? ST_RESP : ST_IDLE;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    mem_lane_unit u_lane (
        .addr_lo   (a_addr[1:0]),
        .len       (a_len),
        .sign      (a_sign),
        .wdata     (a_wdata),
        .rdata     (ram_rdata),
        .lanes     (lanes),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .bad       (bad)
    );

    // All strobes decode from state and latched attributes, so reset clears them at once
    assign acc_ok  = (state == ST_ACCESS) & ~bad;
    assign acc_bad = (state == ST_ACCESS) & bad;
    assign resp    = (state == ST_RESP);

    assign m0_gnt    = acc_ok & ~win;
    assign m1_gnt    = acc_ok & win;
    assign m0_err    = acc_bad & ~win;
    assign m1_err    = acc_bad & win;
    assign m0_rvalid = resp & ~win;
    assign m1_rvalid = resp & win;
    assign m0_rdata  = m0_rvalid ? rdata_ext : '0;
    assign m1_rdata  = m1_rvalid ? rdata_ext : '0;

    assign ram_en    = acc_ok;
    assign ram_we    = (acc_ok & a_we) ? lanes : '0;
    assign ram_addr  = acc_ok ? a_addr[ADDR_W+1:2] : '0;
    assign ram_wdata = (acc_ok & a_we) ? wdata_rep : '0;

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int N_RAND = 300;

  typedef struct {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        sign;
  } req_t;

  typedef struct {
    logic              gnt0, gnt1, err0, err1, en;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              rv0, rv1;
    logic [31:0]       rdata0, rdata1;
    logic              busy_mid, busy_end;
  } obs_t;

  typedef struct {
    int                port;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        len;
    logic              sign;
    logic              exp_err;
    logic [3:0]        exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
    logic [31:0]       exp_rdata;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst_n;
  logic m0_req, m0_we, m0_sign, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_len;
  logic m1_req, m1_we, m1_sign, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_len;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic              busy;
  logic [1:0]        state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_len(m0_len), .m0_sign(m0_sign), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_len(m1_len), .m1_sign(m1_sign), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  // Registered RAM, one-cycle read latency, read-before-write
  logic [31:0] ram_mem [0:63] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_mem[ram_addr[5:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= ram_mem[ram_addr[5:0]];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_mem [0:255] = '{default: '0};
  int last_win = 1;
  req_t idle_req;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] len);
    case (len)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_bad(input req_t r);
    int sz;
    sz = size_of(r.len);
    return (sz == 0) || ((r.addr % sz) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] len, input logic sign);
    int sz;
    longint v;
    sz = size_of(len);
    v = 0;
    for (int i = 0; i < sz; i++) v = v | (longint'(ref_mem[addr + i]) << (8 * i));
    if (sign && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_lanes(input req_t r);
    longint m;
    m = ((longint'(1) << size_of(r.len)) - 1) << (r.addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input req_t r);
    int sz;
    longint unit, rep, v;
    sz = size_of(r.len);
    unit = longint'(r.wdata) % (longint'(1) << (8 * sz));
    rep = 0;
    for (int k = 0; k < 4 / sz; k++) rep = rep + (longint'(1) << (8 * sz * k));
    v = unit * rep;
    return v[31:0];
  endfunction

  function automatic void model_store(input req_t r);
    for (int i = 0; i < size_of(r.len); i++) ref_mem[r.addr + i] = 8'(r.wdata >> (8 * i));
  endfunction

  function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] len, input logic sign);
    req_t r;
    r.en = 1'b1; r.we = we; r.addr = addr; r.wdata = wdata; r.len = len; r.sign = sign;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int v;
    v = $urandom_range(0, 9);
    r.len = (v < 3) ? 2'd0 : (v < 6) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
    r.en = 1'b1;
    r.we = 1'($urandom_range(0, 1));
    r.sign = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.addr = $urandom_range(0, 63);
    if (r.len != 2'd3 && $urandom_range(0, 1) == 1)
      r.addr = r.addr - (r.addr % size_of(r.len));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input req_t r);
    if (p == 0) begin
      m0_req = r.en; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata; m0_len = r.len; m0_sign = r.sign;
    end else begin
      m1_req = r.en; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata; m1_len = r.len; m1_sign = r.sign;
    end
  endtask

  // One arbitration round: both ports present their request, both drop after acceptance
  task automatic do_cycle(input req_t r0, input req_t r1, output obs_t o);
    @(negedge clk);
    set_port(0, r0);
    set_port(1, r1);
    @(posedge clk); #1;
    o.gnt0 = m0_gnt; o.gnt1 = m1_gnt; o.err0 = m0_err; o.err1 = m1_err;
    o.en = ram_en; o.we = ram_we; o.addr = ram_addr; o.wdata = ram_wdata;
    @(negedge clk);
    set_port(0, idle_req);
    set_port(1, idle_req);
    @(posedge clk); #1;
    o.rv0 = m0_rvalid; o.rv1 = m1_rvalid; o.rdata0 = m0_rdata; o.rdata1 = m1_rdata;
    o.busy_mid = busy;
    @(posedge clk); #1;
    o.busy_end = busy;
  endtask

  task automatic check_obs(input string tag, input int port, input logic exp_bad, input logic we,
                           input logic [3:0] exp_lanes, input logic [ADDR_W-1:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata, input obs_t o);
    logic acc, rd;
    acc = !exp_bad;
    rd = acc && !we;
    chk({tag, "_gnt0"}, o.gnt0, acc && port == 0);
    chk({tag, "_gnt1"}, o.gnt1, acc && port == 1);
    chk({tag, "_err0"}, o.err0, exp_bad && port == 0);
    chk({tag, "_err1"}, o.err1, exp_bad && port == 1);
    chk({tag, "_ram_en"}, o.en, acc);
    chk({tag, "_ram_we"}, o.we, (acc && we) ? exp_lanes : 4'b0000);
    if (acc) chk({tag, "_ram_addr"}, o.addr, exp_addr);
    if (acc && we) chk({tag, "_ram_wdata"}, o.wdata, exp_wdata);
    chk({tag, "_rvalid0"}, o.rv0, rd && port == 0);
    chk({tag, "_rvalid1"}, o.rv1, rd && port == 1);
    chk({tag, "_rdata0"}, o.rdata0, (rd && port == 0) ? exp_rdata : 32'h0);
    chk({tag, "_rdata1"}, o.rdata1, (rd && port == 1) ? exp_rdata : 32'h0);
    chk({tag, "_busy_mid"}, o.busy_mid, rd);
    chk({tag, "_busy_end"}, o.busy_end, 1'b0);
  endtask

  task automatic add_vec(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] len, input logic sign, input logic exp_err, input logic [3:0] exp_we,
                         input logic [ADDR_W-1:0] exp_addr, input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.len = len; v.sign = sign;
    v.exp_err = exp_err; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "simulation time limit expired");
  end

  // ---------------- main test ----------------
  initial begin
    obs_t o;
    req_t ra, rb, rw;
    int lat, mode, win;
    int exp_win [3];

    idle_req = '{default: '0};
    rst_n = 1'b0;
    set_port(0, idle_req);
    set_port(1, idle_req);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid, ram_en, busy}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // port, we, addr, wdata, len, sign | err, ram_we, ram_addr, ram_wdata, rdata
    add_vec(0, 1, 32'h10, 32'hDEADBEEF, 2, 0, 0, 4'b1111, 4, 32'hDEADBEEF, 0);
    add_vec(0, 0, 32'h10, 32'h0,        2, 0, 0, 4'b0000, 4, 0, 32'hDEADBEEF);
    add_vec(0, 1, 32'h22, 32'h000000AB, 0, 0, 0, 4'b0100, 8, 32'hABABABAB, 0);
    add_vec(0, 1, 32'h20, 32'h80000000, 2, 0, 0, 4'b1111, 8, 32'h80000000, 0);
    add_vec(0, 0, 32'h23, 32'h0,        0, 1, 0, 4'b0000, 8, 0, 32'hFFFFFF80);
    add_vec(0, 0, 32'h23, 32'h0,        0, 0, 0, 4'b0000, 8, 0, 32'h00000080);
    add_vec(1, 0, 32'h11, 32'h0,        1, 0, 1, 4'b0000, 0, 0, 0);
    add_vec(1, 1, 32'h12, 32'h12345678, 2, 0, 1, 4'b0000, 0, 0, 0);
    add_vec(0, 0, 32'h00, 32'h0,        3, 0, 1, 4'b0000, 0, 0, 0);
    add_vec(1, 1, 32'h16, 32'h00001234, 1, 0, 0, 4'b1100, 5, 32'h12341234, 0);
    add_vec(1, 1, 32'h14, 32'h0000F00D, 1, 0, 0, 4'b0011, 5, 32'hF00DF00D, 0);
    add_vec(1, 0, 32'h14, 32'h0,        1, 1, 0, 4'b0000, 5, 0, 32'hFFFFF00D);
    add_vec(1, 0, 32'h16, 32'h0,        1, 1, 0, 4'b0000, 5, 0, 32'h00001234);
    add_vec(1, 0, 32'h10, 32'h0,        0, 0, 0, 4'b0000, 4, 0, 32'h000000EF);
    add_vec(0, 1, 32'h13, 32'h0000005A, 0, 0, 0, 4'b1000, 4, 32'h5A5A5A5A, 0);
    add_vec(0, 0, 32'h10, 32'h0,        2, 0, 0, 4'b0000, 4, 0, 32'h5AADBEEF);
    add_vec(1, 0, 32'h11, 32'h0,        0, 1, 0, 4'b0000, 4, 0, 32'hFFFFFFBE);

    foreach (vecs[i]) begin
      rw = mk_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].len, vecs[i].sign);
      if (vecs[i].port == 0) do_cycle(rw, idle_req, o);
      else do_cycle(idle_req, rw, o);
      check_obs($sformatf("vec%0d", i), vecs[i].port, vecs[i].exp_err, vecs[i].we, vecs[i].exp_we,
                vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_rdata, o);
      if (!vecs[i].exp_err && vecs[i].we) model_store(rw);
      last_win = vecs[i].port;
    end

    // m1 arrives while m0's read is in flight and must wait until IDLE
    @(negedge clk);
    set_port(0, mk_req(0, 32'h10, 0, 2, 0));
    @(posedge clk); #1;
    chk("bw_m0_gnt", m0_gnt, 1);
    @(negedge clk);
    set_port(0, idle_req);
    set_port(1, mk_req(0, 32'h20, 0, 2, 0));
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("bw_m0_rvalid", m0_rvalid, 1);
        chk("bw_m0_rdata", m0_rdata, model_load(32'h10, 2, 0));
      end
      if (m1_gnt || m1_err) begin
        lat = i;
        break;
      end
    end
    chk("bw_m1_latency", lat, 3);
    @(negedge clk);
    set_port(1, idle_req);
    @(posedge clk); #1;
    chk("bw_m1_rvalid", m1_rvalid, 1);
    chk("bw_m1_rdata", m1_rdata, model_load(32'h20, 2, 0));
    @(posedge clk); #1;
    chk("bw_busy_end", busy, 0);

    // Reset while a read response is on the bus
    @(negedge clk);
    set_port(0, mk_req(0, 32'h10, 0, 2, 0));
    @(posedge clk); #1;
    @(negedge clk);
    set_port(0, idle_req);
    @(posedge clk); #1;
    chk("rr_pre_rvalid", m0_rvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_strobes", {m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid, ram_en, busy}, 0);
    chk("rr_rdata", m0_rdata | m1_rdata, 0);
    chk("rr_ram_bus", {ram_we, ram_addr, ram_wdata} != 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_quiet%0d", i), {m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid, busy}, 0);
    end
    last_win = 1;

    // Simultaneous requests right after reset
`ifdef MEM_ARB_RR_EN
    exp_win = '{0, 1, 0};
`else
    exp_win = '{0, 0, 0};
`endif
    for (int k = 0; k < 3; k++) begin
      ra = mk_req(0, 32'h20, 0, 2, 0);
      rb = mk_req(0, 32'h10, 0, 2, 0);
      do_cycle(ra, rb, o);
      check_obs($sformatf("arb%0d", k), exp_win[k], 0, 0, 0,
                (exp_win[k] == 0) ? 14'd8 : 14'd4, 0,
                model_load((exp_win[k] == 0) ? 32'h20 : 32'h10, 2, 0), o);
    end
    last_win = exp_win[2];

    // Randomized traffic against the byte-memory model
    for (int it = 0; it < N_RAND; it++) begin
      mode = $urandom_range(0, 2);
      ra = rand_req();
      rb = rand_req();
      if (mode == 0) rb = idle_req;
      if (mode == 1) ra = idle_req;
      if (mode == 0) win = 0;
      else if (mode == 1) win = 1;
      else begin
`ifdef MEM_ARB_RR_EN
        win = 1 - last_win;
`else
        win = 0;
`endif
      end
      rw = (win == 0) ? ra : rb;
      do_cycle(ra, rb, o);
      if (is_bad(rw))
        check_obs($sformatf("rnd%0d", it), win, 1, rw.we, 0, 0, 0, 0, o);
      else
        check_obs($sformatf("rnd%0d", it), win, 0, rw.we, model_lanes(rw), ADDR_W'(rw.addr >> 2),
                  model_wdata(rw), model_load(rw.addr, rw.len, rw.sign), o);
      if (!is_bad(rw) && rw.we) model_store(rw);
      last_win = win;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
